// File: rtl/time_set_editor.sv
// Button-driven hours/minutes/seconds editor: debounces five push-buttons,
// edits a local copy of the time and commits it with a one-cycle set_time strobe.
module time_set_editor #(
    parameter int DEBOUNCE_MS = 20,
    parameter int TIMEOUT_MS  = 10000,
    parameter int HR_MAX      = 23
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_1khz,
    input  logic       b_enter,
    input  logic       b_left,
    input  logic       b_right,
    input  logic       b_up,
    input  logic       b_down,
    input  logic [5:0] cur_hrs,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [5:0] set_hrs,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       set_time,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int TO_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_MS - 1);
    localparam logic [5:0]      HR_HI      = 6'(HR_MAX);
    localparam logic [5:0]      HR_LO      = (HR_MAX == 12) ? 6'd1 : 6'd0;
    localparam logic [5:0]      MS_HI      = 6'd59;
    localparam logic [7:0]      BLINK_LAST = 8'd249;

    typedef enum logic [1:0] {ST_IDLE, ST_EDIT, ST_COMMIT} state_t;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] lo,
                                            input logic [5:0] hi);
        return (v >= hi || v < lo) ? lo : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] lo,
                                            input logic [5:0] hi);
        return (v <= lo || v > hi) ? hi : v - 6'd1;
    endfunction

    function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] lo,
                                         input logic [5:0] hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Button bit order doubles as arbitration priority: bit 0 wins.
    logic [4:0] btn_raw, sync1_q, sync2_q, stable_w, stable_prev_q, press;
    assign btn_raw = {b_right, b_left, b_down, b_up, b_enter};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_prev_q <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_w;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_db
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            stable_q, stable_d;

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (sync2_q[gi] == stable_q) begin
                cnt_d = '0;
            end else if (tick_1khz) begin
                if (cnt_q == DB_LAST) begin
                    stable_d = sync2_q[gi];
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign stable_w[gi] = stable_q;
    end

    assign press = stable_w & ~stable_prev_q;

    state_t          state_q, state_d;
    logic [5:0]      hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
    logic [1:0]      field_q, field_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      blink_cnt_q;
    logic            blink_q, set_time_q, editing_q;
    logic [5:0]      set_hrs_q, set_min_q, set_sec_q;

    always_comb begin
        state_d  = state_q;
        hrs_d    = hrs_q;
        min_d    = min_q;
        sec_d    = sec_q;
        field_d  = field_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (press[0]) begin
                    hrs_d    = clamp(cur_hrs, HR_LO, HR_HI);
                    min_d    = cur_min;
                    sec_d    = cur_sec;
                    field_d  = 2'd0;
                    to_cnt_d = '0;
                    state_d  = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (press[0]) begin
                    state_d = ST_COMMIT;
                end else if (press[1] || press[2]) begin
                    case (field_q)
                        2'd0:    hrs_d = press[1] ? wrap_inc(hrs_q, HR_LO, HR_HI)
                                                  : wrap_dec(hrs_q, HR_LO, HR_HI);
                        2'd1:    min_d = press[1] ? wrap_inc(min_q, 6'd0, MS_HI)
                                                  : wrap_dec(min_q, 6'd0, MS_HI);
                        default: sec_d = press[1] ? wrap_inc(sec_q, 6'd0, MS_HI)
                                                  : wrap_dec(sec_q, 6'd0, MS_HI);
                    endcase
                end else if (press[3]) begin
                    field_d = (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
                end else if (press[4]) begin
                    field_d = (field_q >= 2'd2) ? 2'd0 : field_q + 2'd1;
                end
                if (|press) begin
                    to_cnt_d = '0;
                end else if (tick_1khz) begin
                    if (to_cnt_q == TO_LAST) begin
                        to_cnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            hrs_q       <= HR_LO;
            min_q       <= '0;
            sec_q       <= '0;
            field_q     <= '0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            set_hrs_q   <= HR_LO;
            set_min_q   <= '0;
            set_sec_q   <= '0;
            set_time_q  <= 1'b0;
            editing_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hrs_q      <= hrs_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            field_q    <= field_d;
            to_cnt_q   <= to_cnt_d;
            set_time_q <= (state_q == ST_COMMIT);
            editing_q  <= (state_d == ST_EDIT);
            if (state_q == ST_COMMIT) begin
                set_hrs_q <= hrs_q;
                set_min_q <= min_q;
                set_sec_q <= sec_q;
            end
            // Blink phase restarts on every entry into EDIT.
            if (state_d != ST_EDIT || state_q != ST_EDIT) begin
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end else if (tick_1khz) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end
        end
    end

    assign set_hrs   = set_hrs_q;
    assign set_min   = set_min_q;
    assign set_sec   = set_sec_q;
    assign set_time  = set_time_q;
    assign editing   = editing_q;
    assign field_sel = field_q;
    assign blink     = blink_q;
endmodule
